// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit bus master: access sizes,
// AXI response codes, FSM states and the store byte-lane helpers.
package lsu_pkg;

  localparam logic [1:0] SIZE_B        = 2'd0;
  localparam logic [1:0] SIZE_H        = 2'd1;
  localparam logic [1:0] SIZE_W        = 2'd2;
  localparam logic [1:0] SIZE_X        = 2'd3;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_AR  = 3'd1,
    ST_RD_R   = 3'd2,
    ST_WR_REQ = 3'd3,
    ST_WR_B   = 3'd4,
    ST_RESP   = 3'd5
  } lsu_state_e;

  // Byte lanes touched by an access of the given size, before the offset shift
  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  lane_mask = 4'b0001;
      SIZE_H:  lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // True when the access cannot be expressed as a single naturally aligned beat
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  is_misaligned = 1'b0;
      SIZE_H:  is_misaligned = off[0];
      SIZE_W:  is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: places store data on its byte lanes with the
// matching strobes, and extracts/extends load data from a returned word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_off,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [7:0]  st_wstrb,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift;

  // Store steering: shift data and strobes up to the addressed byte lane
  always_comb begin
    st_wdata = st_data << {st_off, 3'b000};
    st_wstrb = {4'b0000, lane_mask(st_size) << st_off};
  end

  // Load extraction: bring the addressed lane down and sign/zero extend
  always_comb begin
    ld_shift = ld_word >> {ld_off, 3'b000};
    case (ld_size)
      SIZE_B:  ld_data = {{24{~ld_unsigned & ld_shift[7]}}, ld_shift[7:0]};
      SIZE_H:  ld_data = {{16{~ld_unsigned & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/lsu_axi_master.sv
// Load/store unit AXI-lite master: one core request at a time, converted into
// a single aligned 32-bit AXI beat; all bus and core outputs are registered.
module lsu_axi_master
  import lsu_pkg::*;
#(
  parameter logic ERR_ON_MISALIGN = 1'b1
) (
  input  logic        aclock,
  input  logic        areset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [7:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  input  logic [1:0]  bresp,
  output logic        bready
);

  lsu_state_e  state_q, state_d;
  logic [1:0]  off_q, off_d, size_q, size_d;
  logic        uns_q, uns_d;
  logic        req_ready_q, req_ready_d, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d, araddr_q, araddr_d, awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        arvalid_q, arvalid_d, rready_q, rready_d, awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d, bready_q, bready_d;
  logic        mis_s, err_now_s, aw_left_s, w_left_s, rd_err_s;
  logic [1:0]  eff_off_s;
  logic [31:0] st_wdata_s, ld_data_s;
  logic [7:0]  st_wstrb_s;

  // With local misalign errors disabled the access is forced onto the word lane
  assign mis_s     = is_misaligned(req_size, req_addr[1:0]);
  assign eff_off_s = mis_s ? 2'b00 : req_addr[1:0];
  assign err_now_s = (req_size == SIZE_X) || (ERR_ON_MISALIGN && mis_s);
  assign rd_err_s  = (rresp != AXI_RESP_OKAY);

  lsu_align u_align (
    .st_off      (eff_off_s),
    .st_size     (req_size),
    .st_data     (req_wdata),
    .st_wdata    (st_wdata_s),
    .st_wstrb    (st_wstrb_s),
    .ld_off      (off_q),
    .ld_size     (size_q),
    .ld_unsigned (uns_q),
    .ld_word     (rdata),
    .ld_data     (ld_data_s)
  );

  // Next-state and next-output computation for the request/transaction FSM
  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    araddr_d     = araddr_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0000_0000;
    arvalid_d    = 1'b0;
    rready_d     = 1'b0;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = 1'b0;
    aw_left_s    = awvalid_q && !awready;
    w_left_s     = wvalid_q && !wready;
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          off_d       = eff_off_s;
          size_d      = req_size;
          uns_d       = req_unsigned;
          if (err_now_s) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_wen) begin
            state_d   = ST_WR_REQ;
            awaddr_d  = {req_addr[31:2], 2'b00};
            wdata_d   = st_wdata_s;
            wstrb_d   = st_wstrb_s;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_RD_AR;
            araddr_d  = {req_addr[31:2], 2'b00};
            arvalid_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_AR: begin
        if (arready) begin
          state_d  = ST_RD_R;
          rready_d = 1'b1;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      ST_RD_R: begin
        if (rvalid) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = rd_err_s;
          resp_rdata_d = rd_err_s ? 32'h0000_0000 : ld_data_s;
        end else begin
          rready_d = 1'b1;
        end
      end
      ST_WR_REQ: begin
        awvalid_d = aw_left_s;
        wvalid_d  = w_left_s;
        if (!aw_left_s && !w_left_s) begin
          state_d  = ST_WR_B;
          bready_d = 1'b1;
        end else begin
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_B: begin
        if (bvalid) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = (bresp != AXI_RESP_OKAY);
        end else begin
          bready_d = 1'b1;
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d   = ST_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs; reset abandons any in-flight beat
  always_ff @(posedge aclock or posedge areset) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      araddr_q     <= 32'h0000_0000;
      awaddr_q     <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      wstrb_q      <= 8'h00;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      araddr_q     <= araddr_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign araddr     = araddr_q;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign awaddr     = awaddr_q;
  assign awvalid    = awvalid_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign wvalid     = wvalid_q;
  assign bready     = bready_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Bench for lsu_axi_master: a cycle-level AXI-lite slave with programmable
// ready delays plus an arithmetic reference for alignment and extension.
module tb_lsu_axi_master;

  logic        aclock, areset;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready;
  logic        bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [7:0]  wstrb;

  int total = 0;
  int bad   = 0;

  // Observations from the most recent run_txn
  int          obs_resp_cnt, obs_resp_cyc, obs_aw_hi, obs_w_hi;
  logic [31:0] obs_rdata, obs_araddr, obs_awaddr, obs_wdata;
  logic [7:0]  obs_wstrb;
  logic        obs_err, obs_ar_seen, obs_aw_seen, obs_bready_early, obs_unstable;
  logic        obs_ready_after;

  lsu_axi_master dut (
    .aclock(aclock), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready)
  );

  initial aclock = 1'b0;
  always #5 aclock = ~aclock;

  // ---------------- reference model ----------------
  function automatic bit m_mis(input logic [31:0] addr, input logic [1:0] size);
    int unsigned off = addr % 4;
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1) return (off % 2) != 0;
    if (size == 2'd2) return off != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] word, input logic [31:0] addr,
                                          input logic [1:0] size, input logic uns);
    int unsigned off = addr % 4;
    int unsigned v = word >> (8 * off);
    if (size == 2'd0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [7:0] m_wstrb(input logic [31:0] addr, input logic [1:0] size);
    int unsigned off = addr % 4;
    if (size == 2'd0) return 8'(1 << off);
    if (size == 2'd1) return 8'(3 << off);
    return 8'd15;
  endfunction

  function automatic int m_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // ---------------- stimulus + slave ----------------
  task automatic clear_slave();
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
  endtask

  task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] size, input logic uns, input logic [31:0] sword,
                         input logic [1:0] sresp, input int ar_wait, input int aw_wait,
                         input int w_wait);
    bit ar_pend = 0, r_pend = 0, aw_done = 0, w_done = 0, b_issued = 0, b_pend = 0;
    int ar_hi = 0, aw_hi = 0, w_hi = 0, waitc = 0;
    logic [31:0] first_wdata = 32'h0, first_awaddr = 32'h0;
    obs_resp_cnt = 0; obs_resp_cyc = -1; obs_rdata = 32'hx; obs_err = 1'bx;
    obs_ar_seen = 0; obs_aw_seen = 0; obs_bready_early = 0; obs_unstable = 0;
    obs_araddr = 32'hx; obs_awaddr = 32'hx; obs_wdata = 32'hx; obs_wstrb = 8'hx;
    obs_ready_after = 1'b0; obs_aw_hi = 0; obs_w_hi = 0;
    clear_slave();
    @(negedge aclock);
    while (!req_ready && waitc < 20) begin @(negedge aclock); waitc++; end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL req_ready_timeout got=0 exp=1");
      return;
    end
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd;
    req_size = size; req_unsigned = uns;
    for (int c = 1; c <= 60; c++) begin
      @(negedge aclock);
      if (c == 1) req_valid = 1'b0;
      if (r_pend) begin rvalid = 1'b0; r_pend = 0; end
      if (ar_pend) begin rvalid = 1'b1; rdata = sword; rresp = sresp; ar_pend = 0; end
      if (b_pend) begin bvalid = 1'b0; b_pend = 0; end
      if (aw_done && w_done && !b_issued) begin bvalid = 1'b1; bresp = sresp; b_issued = 1; end
      if (bready && !(aw_done && w_done)) obs_bready_early = 1;
      if (resp_valid) begin
        if (obs_resp_cnt == 0) begin
          obs_resp_cyc = c; obs_rdata = resp_rdata; obs_err = resp_err;
        end
        obs_resp_cnt++;
      end
      if (obs_resp_cnt > 0 && c == obs_resp_cyc + 1) begin
        obs_ready_after = req_ready;
        break;
      end
      if (arvalid) obs_ar_seen = 1;
      if (awvalid) obs_aw_seen = 1;
      arready = arvalid && (ar_hi >= ar_wait);
      if (arvalid) ar_hi++;
      if (arvalid && arready) begin ar_pend = 1; obs_araddr = araddr; end
      r_pend = rvalid && rready;
      if (wvalid) begin
        if (w_hi == 0) first_wdata = wdata; else if (wdata !== first_wdata) obs_unstable = 1;
      end
      if (awvalid) begin
        if (aw_hi == 0) first_awaddr = awaddr; else if (awaddr !== first_awaddr) obs_unstable = 1;
      end
      awready = awvalid && (aw_hi >= aw_wait);
      wready  = wvalid && (w_hi >= w_wait);
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (awvalid && awready) begin aw_done = 1; obs_awaddr = awaddr; end
      if (wvalid && wready) begin w_done = 1; obs_wdata = wdata; obs_wstrb = wstrb; end
      if (bvalid && bready) b_pend = 1;
      obs_aw_hi = aw_hi; obs_w_hi = w_hi;
    end
    clear_slave();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    areset = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_size = 2'd0; req_unsigned = 1'b0;
    clear_slave();
    repeat (3) @(negedge aclock);
    total++;
    if ({req_ready, resp_valid, arvalid, rready, awvalid, wvalid, bready} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0", {req_ready, resp_valid, arvalid, rready, awvalid, wvalid, bready});
    end
    total++;
    if ({araddr, awaddr, wdata, wstrb, resp_rdata, resp_err} !== 137'b0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {araddr, awaddr, wdata, wstrb});
    end
    areset = 1'b0;
    @(negedge aclock);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_loads();
    run_txn(1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0);
    total++; if (obs_araddr !== 32'h8000_0004) begin bad++; $display("FAIL lw_araddr got=%h exp=80000004", obs_araddr); end
    total++; if (obs_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_rdata got=%h exp=deadbeef", obs_rdata); end
    total++; if (obs_err !== 1'b0) begin bad++; $display("FAIL lw_err got=%b exp=0", obs_err); end
    total++; if (obs_resp_cyc != 3) begin bad++; $display("FAIL lw_latency got=%0d exp=3", obs_resp_cyc); end
    run_txn(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b0, 32'h80FF_0000, 2'b00, 0, 0, 0);
    total++; if (obs_rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rdata got=%h exp=ffffff80", obs_rdata); end
    total++; if (obs_araddr !== 32'h8000_0000) begin bad++; $display("FAIL lb_araddr got=%h exp=80000000", obs_araddr); end
    run_txn(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b1, 32'h80FF_0000, 2'b00, 0, 0, 0);
    total++; if (obs_rdata !== 32'h0000_80FF) begin bad++; $display("FAIL lhu_rdata got=%h exp=000080ff", obs_rdata); end
  endtask

  task automatic test_stores();
    run_txn(1'b1, 32'h8000_0001, 32'h0000_00AB, 2'd0, 1'b0, 32'h0, 2'b00, 0, 0, 0);
    total++; if (obs_awaddr !== 32'h8000_0000) begin bad++; $display("FAIL sb_awaddr got=%h exp=80000000", obs_awaddr); end
    total++; if (obs_wdata !== 32'h0000_AB00) begin bad++; $display("FAIL sb_wdata got=%h exp=0000ab00", obs_wdata); end
    total++; if (obs_wstrb !== 8'h02) begin bad++; $display("FAIL sb_wstrb got=%h exp=02", obs_wstrb); end
    total++; if (obs_resp_cyc != 3 || obs_rdata !== 32'h0) begin bad++; $display("FAIL sb_resp got=%0d/%h exp=3/0", obs_resp_cyc, obs_rdata); end
    run_txn(1'b1, 32'h8000_0002, 32'h0000_1234, 2'd1, 1'b0, 32'h0, 2'b00, 0, 0, 0);
    total++; if (obs_wdata !== 32'h1234_0000) begin bad++; $display("FAIL sh_wdata got=%h exp=12340000", obs_wdata); end
    total++; if (obs_wstrb !== 8'h0C) begin bad++; $display("FAIL sh_wstrb got=%h exp=0c", obs_wstrb); end
  endtask

  task automatic test_write_backpressure();
    run_txn(1'b1, 32'h8000_0010, 32'hCAFE_F00D, 2'd2, 1'b0, 32'h0, 2'b10, 0, 3, 0);
    total++; if (obs_w_hi != 1) begin bad++; $display("FAIL bp_wvalid_cycles got=%0d exp=1", obs_w_hi); end
    total++; if (obs_aw_hi != 4) begin bad++; $display("FAIL bp_awvalid_cycles got=%0d exp=4", obs_aw_hi); end
    total++; if (obs_bready_early !== 1'b0) begin bad++; $display("FAIL bp_bready_early got=1 exp=0"); end
    total++; if (obs_err !== 1'b1) begin bad++; $display("FAIL bp_err got=%b exp=1", obs_err); end
    total++; if (obs_resp_cyc != 6) begin bad++; $display("FAIL bp_latency got=%0d exp=6", obs_resp_cyc); end
  endtask

  task automatic test_misalign();
    run_txn(1'b0, 32'h8000_0002, 32'h0, 2'd2, 1'b0, 32'h1111_1111, 2'b00, 0, 0, 0);
    total++; if (obs_ar_seen !== 1'b0) begin bad++; $display("FAIL mis_arvalid got=1 exp=0"); end
    total++; if (obs_resp_cyc != 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
      bad++; $display("FAIL mis_resp got=%0d/%b/%h exp=1/1/0", obs_resp_cyc, obs_err, obs_rdata); end
    run_txn(1'b1, 32'h8000_0000, 32'h0, 2'd3, 1'b0, 32'h0, 2'b00, 0, 0, 0);
    total++; if (obs_aw_seen !== 1'b0 || obs_resp_cyc != 1 || obs_err !== 1'b1) begin
      bad++; $display("FAIL size3_resp got=%b/%0d/%b exp=0/1/1", obs_aw_seen, obs_resp_cyc, obs_err); end
  endtask

  task automatic test_reset_mid();
    int waitc = 0;
    clear_slave();
    @(negedge aclock);
    while (!req_ready && waitc < 20) begin @(negedge aclock); waitc++; end
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0008; req_size = 2'd2; req_unsigned = 1'b0;
    @(negedge aclock);
    req_valid = 1'b0;
    arready = 1'b1;
    @(negedge aclock);
    arready = 1'b0;
    total++; if (rready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_rd_r got=%b exp=1", rready); end
    #2 areset = 1'b1;
    #1;
    total++;
    if ({req_ready, resp_valid, arvalid, rready, awvalid, wvalid, bready, araddr, resp_rdata} !== 71'b0) begin
      bad++; $display("FAIL rst_mid_outputs got=%b exp=0", {req_ready, resp_valid, arvalid, rready});
    end
    @(negedge aclock);
    areset = 1'b0;
    @(negedge aclock);
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid_release got=%b/%b exp=1/0", req_ready, resp_valid); end
    run_txn(1'b0, 32'h8000_000C, 32'h0, 2'd2, 1'b0, 32'h0BAD_F00D, 2'b00, 0, 0, 0);
    total++; if (obs_rdata !== 32'h0BAD_F00D || obs_resp_cyc != 3) begin
      bad++; $display("FAIL rst_mid_next got=%h/%0d exp=0badf00d/3", obs_rdata, obs_resp_cyc); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] w = $urandom;
      run_txn(1'b0, 32'h8000_0100 + 32'(4 * i), 32'h0, 2'd2, 1'b0, w, 2'b00, 0, 0, 0);
      total++; if (obs_rdata !== w) begin bad++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", i, obs_rdata, w); end
      total++; if (obs_ready_after !== 1'b1 || obs_resp_cnt != 1) begin
        bad++; $display("FAIL b2b_ready_after[%0d] got=%b/%0d exp=1/1", i, obs_ready_after, obs_resp_cnt); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic        wen  = 1'($urandom_range(0, 1));
      logic [31:0] addr = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
      logic [1:0]  size = 2'($urandom_range(0, 3));
      logic        uns  = 1'($urandom_range(0, 1));
      logic [31:0] wd   = $urandom;
      logic [31:0] word = $urandom;
      logic [1:0]  sr   = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00;
      int arw = $urandom_range(0, 3);
      int aww = $urandom_range(0, 3);
      int ww  = $urandom_range(0, 3);
      logic [31:0] exp_rd;
      int exp_cyc;
      run_txn(wen, addr, wd, size, uns, word, sr, arw, aww, ww);
      total++; if (obs_resp_cnt != 1) begin bad++; $display("FAIL rnd[%0d]_pulses got=%0d exp=1", i, obs_resp_cnt); end
      total++; if (obs_ready_after !== 1'b1) begin bad++; $display("FAIL rnd[%0d]_ready_after got=%b exp=1", i, obs_ready_after); end
      if (m_mis(addr, size)) begin
        total++;
        if (obs_resp_cyc != 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_ar_seen || obs_aw_seen) begin
          bad++; $display("FAIL rnd[%0d]_mis got=%0d/%b/%h exp=1/1/0", i, obs_resp_cyc, obs_err, obs_rdata);
        end
      end else if (!wen) begin
        exp_rd  = (sr != 2'b00) ? 32'h0 : m_rdata(word, addr, size, uns);
        exp_cyc = 3 + arw;
        total++; if (obs_araddr !== (addr & 32'hFFFF_FFFC)) begin
          bad++; $display("FAIL rnd[%0d]_araddr got=%h exp=%h", i, obs_araddr, addr & 32'hFFFF_FFFC); end
        total++; if (obs_rdata !== exp_rd || obs_err !== (sr != 2'b00)) begin
          bad++; $display("FAIL rnd[%0d]_load got=%h/%b exp=%h/%b", i, obs_rdata, obs_err, exp_rd, sr != 2'b00); end
        total++; if (obs_resp_cyc != exp_cyc || obs_aw_seen) begin
          bad++; $display("FAIL rnd[%0d]_load_cyc got=%0d exp=%0d", i, obs_resp_cyc, exp_cyc); end
      end else begin
        exp_cyc = 3 + m_max(aww, ww);
        total++; if (obs_awaddr !== (addr & 32'hFFFF_FFFC)) begin
          bad++; $display("FAIL rnd[%0d]_awaddr got=%h exp=%h", i, obs_awaddr, addr & 32'hFFFF_FFFC); end
        total++; if (obs_wdata !== (wd << (8 * (addr % 4))) || obs_wstrb !== m_wstrb(addr, size)) begin
          bad++; $display("FAIL rnd[%0d]_wlane got=%h/%h exp=%h/%h", i, obs_wdata, obs_wstrb,
                          wd << (8 * (addr % 4)), m_wstrb(addr, size)); end
        total++; if (obs_err !== (sr != 2'b00) || obs_rdata !== 32'h0) begin
          bad++; $display("FAIL rnd[%0d]_store_resp got=%b/%h exp=%b/0", i, obs_err, obs_rdata, sr != 2'b00); end
        total++; if (obs_resp_cyc != exp_cyc || obs_bready_early || obs_unstable || obs_ar_seen) begin
          bad++; $display("FAIL rnd[%0d]_store_seq got=%0d/%b/%b exp=%0d/0/0", i, obs_resp_cyc,
                          obs_bready_early, obs_unstable, exp_cyc); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_write_backpressure();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
